instr_fetch: RTL and testbench

RV32I fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the fetch address into the combinational instruction memory. It captures the returned word with its PC into a 2-entry buffer, which feeds decode through a valid/ready handshake. It also handles control-flow redirects, flushes and misaligned-PC faults.

---
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, drives a combinational instruction memory
// and queues {pc, instr, fault} entries in a 2-deep FIFO towards decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] bpc_q [2];
  logic [31:0] bpc_d [2];
  logic [31:0] bins_q [2];
  logic [31:0] bins_d [2];
  logic        bflt_q [2];
  logic        bflt_d [2];

  logic fire;
  logic pop;
  logic wr;
  logic misal;

  assign out_valid = cnt_q != 2'd0;
  assign pop       = out_valid & out_ready;
  assign fire      = rst_n & (state_q == RUN) & ~redirect_valid
                   & (cnt_q < 2'(DEPTH));
  assign wr        = rd_q ^ cnt_q[0];
  assign misal     = |pc_q[1:0];

  assign imem_addr   = pc_q;
  assign imem_en     = fire;
  assign out_pc      = out_valid ? bpc_q[rd_q]  : 32'h0;
  assign out_instr   = out_valid ? bins_q[rd_q] : 32'h0;
  assign out_fault   = out_valid & bflt_q[rd_q];
  assign fetch_count = fcnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    fcnt_d  = fcnt_q;
    bpc_d   = bpc_q;
    bins_d  = bins_q;
    bflt_d  = bflt_q;
    if (redirect_valid) begin
      // Flush wins over any pop seen this cycle.
      pc_d    = redirect_pc;
      state_d = RUN;
      cnt_d   = 2'd0;
      rd_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + 2'(fire) - 2'(pop);
      if (fire) begin
        fcnt_d     = fcnt_q + 32'd1;
        bpc_d[wr]  = pc_q;
        bins_d[wr] = misal ? 32'h0000_0013 : imem_instr;
        bflt_d[wr] = misal;
        if (misal) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      rd_q    <= 1'b0;
      fcnt_q  <= 32'h0;
      bpc_q   <= '{default: 32'h0};
      bins_q  <= '{default: 32'h0};
      bflt_q  <= '{default: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
      bpc_q   <= bpc_d;
      bins_q  <= bins_d;
      bflt_q  <= bflt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        f;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  logic        halted;
  logic [31:0] mcnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_fire();
    return !halted && !redirect_valid && q.size() < 2;
  endfunction

  task automatic compare();
    chk("imem_addr", imem_addr, mpc);
    chk("imem_en", 32'(imem_en), 32'(exp_fire()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("fetch_count", fetch_count, mcnt);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].ins);
      chk("out_fault", 32'(out_fault), 32'(q[0].f));
    end
  endtask

  task automatic step();
    ent_t e;
    logic f;
    f = exp_fire();
    if (redirect_valid) begin
      q.delete();
      mpc    = redirect_pc;
      halted = 1'b0;
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (f) begin
        mcnt = mcnt + 32'd1;
        e.pc = mpc;
        if (mpc[1:0] != 2'b00) begin
          e.ins  = 32'h0000_0013;
          e.f    = 1'b1;
          halted = 1'b1;
        end else begin
          e.ins = mem(mpc);
          e.f   = 1'b0;
          mpc   = mpc + 32'd4;
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rpc,
                     input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    compare();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    chk("rst_imem_en", 32'(imem_en), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    q.delete();
    mpc    = 32'h0;
    halted = 1'b0;
    mcnt   = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    do_reset();

    // streaming at one instruction per cycle
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_pc4", out_pc, 32'h4);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_pc8", out_pc, 32'h8);
    chk("t1_instr8", out_instr, mem(32'h8));
    chk("t1_count", fetch_count, 32'd3);

    // backpressure fills the buffer then drains in order
    do_reset();
    repeat (5) cyc(1'b0, 32'h0, 1'b0);
    chk("t2_pc0", out_pc, 32'h0);
    chk("t2_addr", imem_addr, 32'h8);
    chk("t2_count", fetch_count, 32'd2);
    chk("t2_en", 32'(imem_en), 32'h0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t2_pc4", out_pc, 32'h4);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t2_pc8", out_pc, 32'h8);

    // redirect flushes a full buffer
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);
    chk("t3_flush", 32'(out_valid), 32'h0);
    chk("t3_count", fetch_count, 32'd4);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t3_pc100", out_pc, 32'h100);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t3_pc104", out_pc, 32'h104);

    // misaligned target faults and halts until the next redirect
    cyc(1'b1, 32'h102, 1'b1);
    chk("t4_flush", 32'(out_valid), 32'h0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("t4_pc", out_pc, 32'h102);
    chk("t4_instr", out_instr, 32'h13);
    chk("t4_fault", 32'(out_fault), 32'h1);
    repeat (4) cyc(1'b0, 32'h0, 1'b1);
    chk("t4_halt_en", 32'(imem_en), 32'h0);
    chk("t4_halt_addr", imem_addr, 32'h102);
    cyc(1'b1, 32'h200, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t4_pc200", out_pc, 32'h200);

    // PC wraps at the top of the address space
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("t5_pctop", out_pc, 32'hFFFF_FFFC);
    chk("t5_addr", imem_addr, 32'h4);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t5_pc0", out_pc, 32'h0);
    chk("t5_fault", 32'(out_fault), 32'h0);

    // asynchronous reset in the middle of a cycle
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    chk("t6_pc", out_pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       rpc = $urandom() | 32'h1;
        1:       rpc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
        default: rpc = $urandom() & 32'hFFFF_FFFC;
      endcase
      cyc($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
